// File: rtl/fifo_stream_buf_if.sv
// Valid/ready stream bundle for both sides of fifo_stream_buf.
// master = producer/consumer environment, slave = the FIFO itself.
interface fifo_stream_buf_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fifo_stream_buf.sv
// First-word-fall-through stream FIFO with occupancy flags, flush,
// sticky overflow and high-water mark; buffers between butterfly stages.
module fifo_stream_buf #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 32,
    parameter int AFULL_THRESH  = DEPTH - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    fifo_stream_buf_if.slave        bus,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  hwm
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);
    localparam logic [AW:0] AF_TH   = (AW+1)'(AFULL_THRESH);
    localparam logic [AW:0] AE_TH   = (AW+1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic [AW:0]           r_count;
    logic [AW:0]           r_hwm;
    logic                  r_overflow;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic [AW:0]           w_count_next;
    logic [AW:0]           w_hwm_next;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign bus.in_ready  = !w_full && !rst;
    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    assign w_push = bus.in_valid && bus.in_ready;
    assign w_pop  = bus.out_ready && !w_empty;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop)
            w_count_next = r_count + ONE;
        else if (w_pop && !w_push)
            w_count_next = r_count - ONE;
        w_hwm_next = (w_count_next > r_hwm) ? w_count_next : r_hwm;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_hwm      <= '0;
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_hwm      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + ONE;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + ONE;
            r_count    <= w_count_next;
            r_hwm      <= w_hwm_next;
            r_overflow <= r_overflow | (bus.in_valid && w_full);
        end
    end

    // Storage is not reset; w_push already excludes rst, clr discards the write.
    always_ff @(posedge clk) begin
        if (w_push && !clr)
            r_mem[r_wr_ptr[AW-1:0]] <= bus.in_data;
    end

    assign count        = r_count;
    assign hwm          = r_hwm;
    assign overflow     = r_overflow;
    assign almost_full  = (r_count >= AF_TH);
    assign almost_empty = (r_count <= AE_TH);
endmodule

// File: tb/tb_fifo_stream_buf.sv
// Directed bench for fifo_stream_buf: the driver queues expected words,
// a negedge monitor pops and compares every output handshake.
module tb_fifo_stream_buf;
    localparam int DW = 8;
    localparam int DEPTH = 32;

    logic       clk;
    logic       rst;
    logic       clr;
    logic [5:0] count;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic [5:0] hwm;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] sb[$];

    fifo_stream_buf_if #(.DATA_WIDTH(DW)) bus ();

    fifo_stream_buf #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(DEPTH-4), .AEMPTY_THRESH(4)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr), .bus(bus),
        .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .hwm(hwm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // One clock of stimulus; acc marks a push the FIFO is expected to accept.
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy,
                        input logic c, input logic acc);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        clr           = c;
        if (acc) sb.push_back(d);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got 0x%0h, expected no output", bus.out_data);
            end else begin
                logic [DW-1:0] e;
                e = sb.pop_front();
                $display("pop data=0x%02h expected=0x%02h count=%0d", bus.out_data, e, count);
                chk("pop_data", bus.out_data, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; clr = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        #12;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_count", count, 0);
        chk("rst_aempty", almost_empty, 1);
        chk("rst_afull", almost_full, 0);
        chk("rst_hwm", hwm, 0);
        chk("rst_overflow", overflow, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);

        // 1: single word falls through one cycle after the push edge
        step(1, 8'hA5, 0, 0, 1);
        chk("t1_out_valid", bus.out_valid, 1);
        chk("t1_out_data", bus.out_data, 8'hA5);
        chk("t1_count", count, 1);
        step(0, 0, 1, 0, 0);
        chk("t1_count_after_pop", count, 0);

        // 2: fill to full, reject an extra push, drain in order
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 8'(i), 0, 0, 1);
            if (i == 26) chk("t2_afull_at27", almost_full, 0);
            if (i == 27) chk("t2_afull_at28", almost_full, 1);
        end
        chk("t2_count_full", count, 32);
        chk("t2_in_ready_full", bus.in_ready, 0);
        chk("t2_hwm_full", hwm, 32);
        chk("t2_overflow_before", overflow, 0);
        step(1, 8'hFF, 0, 0, 0);
        chk("t2_overflow", overflow, 1);
        chk("t2_count_after_reject", count, 32);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, 1, 0, 0);
            if (i == 26) chk("t2_aempty_at5", almost_empty, 0);
            if (i == 27) chk("t2_aempty_at4", almost_empty, 1);
        end
        chk("t2_count_empty", count, 0);
        chk("t2_out_valid_end", bus.out_valid, 0);
        chk("t2_out_data_end", bus.out_data, 0);
        chk("t2_overflow_sticky", overflow, 1);

        // 3: steady state at 16 with pointers wrapping
        for (int i = 0; i < 16; i++) step(1, 8'(8'h40 + i), 0, 0, 1);
        for (int i = 0; i < 100; i++) begin
            step(1, 8'(8'h50 + i), 1, 0, 1);
            if (i % 25 == 24) chk("t3_count_steady", count, 16);
        end
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0);
        chk("t3_count_drained", count, 0);

        // 4: push+pop on full pops only; on empty pushes only
        for (int i = 0; i < DEPTH; i++) step(1, 8'(8'hC0 + i), 0, 0, 1);
        step(1, 8'h11, 1, 0, 0);
        chk("t4_count_full_pp", count, 31);
        for (int i = 0; i < 31; i++) step(0, 0, 1, 0, 0);
        chk("t4_count_empty", count, 0);
        step(1, 8'h22, 1, 0, 1);
        chk("t4_count_empty_pp", count, 1);
        chk("t4_out_data_empty_pp", bus.out_data, 8'h22);
        step(0, 0, 1, 0, 0);

        // 5: flush clears counters and discards a coinciding push
        step(0, 0, 0, 1, 0);
        chk("t5_hwm_cleared", hwm, 0);
        chk("t5_overflow_cleared", overflow, 0);
        for (int i = 0; i < 20; i++) step(1, 8'(8'h70 + i), 0, 0, 1);
        chk("t5_hwm_20", hwm, 20);
        for (int i = 0; i < 15; i++) step(0, 0, 1, 0, 0);
        chk("t5_count_5", count, 5);
        chk("t5_hwm_held", hwm, 20);
        bus.in_valid = 1'b1; bus.in_data = 8'h99; bus.out_ready = 1'b0; clr = 1'b1;
        #1;
        chk("t5_in_ready_during_clr", bus.in_ready, 1);
        @(posedge clk); #1;
        sb.delete();
        bus.in_valid = 1'b0; clr = 1'b0;
        #1;
        chk("t5_count_clr", count, 0);
        chk("t5_hwm_clr", hwm, 0);
        chk("t5_overflow_clr", overflow, 0);
        chk("t5_out_valid_clr", bus.out_valid, 0);
        chk("t5_out_data_clr", bus.out_data, 0);

        // 6: asynchronous reset mid-burst
        for (int i = 0; i < 10; i++) step(1, 8'(8'h30 + i), 0, 0, 1);
        chk("t6_count_10", count, 10);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_out_valid_async", bus.out_valid, 0);
        chk("t6_count_async", count, 0);
        chk("t6_in_ready_async", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        step(0, 0, 1, 0, 0);
        chk("t6_count_after", count, 0);
        chk("t6_in_ready_after", bus.in_ready, 1);
        chk("t6_hwm_after", hwm, 0);
        chk("sb_empty_end", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
